// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - instruction-fetch buffer between the PC register and decode
//
// Captures {pc_in, instr_in} every cycle the queue can take it, presents the
// oldest pair to decode through a valid/ready handshake, and drives the PC
// register enable so fetch stalls while the queue is full. A flush from decode
// discards all queued work and the fetch in flight.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   pc_in      current PC (PC register output)
//   instr_in   instruction-memory word for pc_in, same cycle
//   flush      redirect: drop queue contents and the current fetch
//   id_ready   decode accepts the head entry this cycle
//   pc_enable  PC register enable (current fetch consumed, or redirect)
//   id_valid   head entry present
//   id_pc      PC of head entry (0 when empty)
//   id_instr   instruction of head entry (0 when empty)
//   id_pc8     id_pc + 8, link address for jal/jalr (0 when empty)
//   count      number of occupied entries, 0..DEPTH

module fetch_queue #(
    parameter int DEPTH = 4,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = PW + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [31:0]   pc_in,
    input  logic [31:0]   instr_in,
    input  logic          flush,
    input  logic          id_ready,
    output logic          pc_enable,
    output logic          id_valid,
    output logic [31:0]   id_pc,
    output logic [31:0]   id_instr,
    output logic [31:0]   id_pc8,
    output logic [CW-1:0] count
);

    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
    localparam logic [PW-1:0] PTR_ONE    = PW'(1);

    // Entry layout: {pc, instr}
    logic [63:0]   mem_q [DEPTH];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;

    logic          full;
    logic          push;
    logic          pop;
    logic [63:0]   head;

    assign full     = (count_q == FULL_COUNT);
    assign id_valid = (count_q != '0);

    // Flush blocks both sides. A pop frees a slot in the same cycle, so a full
    // queue can still take the current fetch when decode drains the head.
    assign pop       = id_valid & id_ready & ~flush;
    assign push      = ~flush & (~full | pop);

    // On flush the PC must load the redirect target, so it is enabled even
    // though nothing is pushed. With full and no pop the PC holds and the
    // same address is simply re-fetched next cycle.
    assign pc_enable = push | flush;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end
            unique case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is cleared by reset only; a flush just rewinds the pointers and
    // leaves stale entries behind, which are never visible while count is 0.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push) begin
            mem_q[wr_ptr_q] <= {pc_in, instr_in};
        end
    end

    // Head outputs come from registered state only; the zero-mask keeps stale
    // storage off the decode bus while the queue is empty.
    assign head     = mem_q[rd_ptr_q];
    assign id_pc    = id_valid ? head[63:32] : 32'h0;
    assign id_instr = id_valid ? head[31:0]  : 32'h0;
    assign id_pc8   = id_valid ? (head[63:32] + 32'd8) : 32'h0;
    assign count    = count_q;

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - self-checking bench for fetch_queue

module tb_fetch_queue;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc_in;
    logic [31:0] instr_in;
    logic        flush;
    logic        id_ready;
    logic        pc_enable;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_instr;
    logic [31:0] id_pc8;
    logic [2:0]  count;

    int          checks   = 0;
    int          failures = 0;

    logic [31:0] pc;
    logic [31:0] target;
    logic [63:0] sb[$];

    always #5 clk = ~clk;

    assign pc_in    = pc;
    assign instr_in = pc ^ 32'hDEAD_BEEF;

    fetch_queue #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .pc_in     (pc_in),
        .instr_in  (instr_in),
        .flush     (flush),
        .id_ready  (id_ready),
        .pc_enable (pc_enable),
        .id_valid  (id_valid),
        .id_pc     (id_pc),
        .id_instr  (id_instr),
        .id_pc8    (id_pc8),
        .count     (count)
    );

    // Advances one clock; the bench's own PC register and queue model follow
    // the handshake rules from the current inputs, never from DUT outputs.
    task automatic tick();
        logic        m_pop;
        logic        m_push;
        logic [63:0] ent;
        m_pop  = reset && !flush && id_ready && (sb.size() != 0);
        m_push = reset && !flush && ((sb.size() < DEPTH) || m_pop);
        ent    = {pc_in, instr_in};
        @(posedge clk);
        #1;
        if (!reset) begin
            sb.delete();
        end else if (flush) begin
            sb.delete();
            pc = target;
        end else begin
            if (m_pop) void'(sb.pop_front());
            if (m_push) begin
                sb.push_back(ent);
                pc = pc + 32'd4;
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        #2;
        checks++; if (count !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
        checks++; if (id_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", id_valid); end
        checks++; if ({id_pc, id_instr, id_pc8} !== 96'h0) begin failures++; $display("FAIL reset_head got=%h %h %h exp=0", id_pc, id_instr, id_pc8); end
        checks++; if (pc_enable !== 1'b1) begin failures++; $display("FAIL reset_pc_enable got=%b exp=1", pc_enable); end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_pass_through();
        logic [31:0] exp_pc;
        id_ready = 1'b1;
        #1;
        checks++; if (id_valid !== 1'b0 || count !== 3'd0) begin failures++; $display("FAIL empty_ready got valid=%b count=%0d exp 0 0", id_valid, count); end
        checks++; if (pc_enable !== 1'b1) begin failures++; $display("FAIL empty_pc_enable got=%b exp=1", pc_enable); end
        tick();
        for (int i = 0; i < 3; i++) begin
            exp_pc = 32'h3000 + 32'(4 * i);
            checks++; if (id_valid !== 1'b1 || id_pc !== exp_pc) begin failures++; $display("FAIL pass_pc[%0d] got valid=%b pc=%h exp pc=%h", i, id_valid, id_pc, exp_pc); end
            checks++; if (id_instr !== (exp_pc ^ 32'hDEAD_BEEF)) begin failures++; $display("FAIL pass_instr[%0d] got=%h exp=%h", i, id_instr, exp_pc ^ 32'hDEAD_BEEF); end
            checks++; if (id_pc8 !== exp_pc + 32'd8) begin failures++; $display("FAIL pass_pc8[%0d] got=%h exp=%h", i, id_pc8, exp_pc + 32'd8); end
            checks++; if (count !== 3'd1 || pc_enable !== 1'b1) begin failures++; $display("FAIL pass_count[%0d] got count=%0d pe=%b exp 1 1", i, count, pc_enable); end
            tick();
        end
    endtask

    task automatic test_fill();
        logic [2:0] exp_count;
        flush = 1'b1; target = 32'h3000; id_ready = 1'b0;
        tick();
        flush = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            exp_count = (i < 3) ? 3'(i + 1) : 3'd4;
            checks++; if (count !== exp_count) begin failures++; $display("FAIL fill_count[%0d] got=%0d exp=%0d", i, count, exp_count); end
            checks++; if (pc_enable !== (exp_count != 3'd4)) begin failures++; $display("FAIL fill_pc_enable[%0d] got=%b exp=%b", i, pc_enable, exp_count != 3'd4); end
            checks++; if (id_pc !== 32'h3000) begin failures++; $display("FAIL fill_head[%0d] got=%h exp=00003000", i, id_pc); end
        end
    endtask

    task automatic test_full_pop();
        logic [31:0] exp_pc;
        id_ready = 1'b1;
        #1;
        checks++; if (pc_enable !== 1'b1) begin failures++; $display("FAIL fullpop_pc_enable got=%b exp=1", pc_enable); end
        tick();
        checks++; if (count !== 3'd4) begin failures++; $display("FAIL fullpop_count got=%0d exp=4", count); end
        for (int i = 0; i < 4; i++) begin
            exp_pc = 32'h3004 + 32'(4 * i);
            checks++; if (id_pc !== exp_pc || {id_pc, id_instr} !== sb[0]) begin failures++; $display("FAIL drain[%0d] got=%h %h exp=%h", i, id_pc, id_instr, sb[0]); end
            tick();
        end
    endtask

    task automatic test_flush_ready();
        flush = 1'b1; target = 32'h5000;
        tick();
        flush = 1'b0; id_ready = 1'b0;
        repeat (3) tick();
        checks++; if (count !== 3'd3) begin failures++; $display("FAIL flush_pre_count got=%0d exp=3", count); end
        flush = 1'b1; id_ready = 1'b1; target = 32'h8000;
        #1;
        checks++; if (pc_enable !== 1'b1) begin failures++; $display("FAIL flush_pc_enable got=%b exp=1", pc_enable); end
        tick();
        flush = 1'b0;
        #1;
        checks++; if (count !== 3'd0 || id_valid !== 1'b0) begin failures++; $display("FAIL flush_empty got count=%0d valid=%b exp 0 0", count, id_valid); end
        checks++; if ({id_pc, id_instr, id_pc8} !== 96'h0) begin failures++; $display("FAIL flush_head_zero got=%h %h %h exp=0", id_pc, id_instr, id_pc8); end
        tick();
        checks++; if (id_valid !== 1'b1 || id_pc !== 32'h8000 || count !== 3'd1) begin failures++; $display("FAIL redirect_head got valid=%b pc=%h count=%0d exp 1 00008000 1", id_valid, id_pc, count); end
    endtask

    task automatic test_async_reset();
        id_ready = 1'b0;
        tick();
        checks++; if (count !== 3'd2) begin failures++; $display("FAIL areset_pre_count got=%0d exp=2", count); end
        #2;
        reset = 1'b0;
        #1;
        checks++; if (count !== 3'd0 || id_valid !== 1'b0) begin failures++; $display("FAIL areset_state got count=%0d valid=%b exp 0 0", count, id_valid); end
        checks++; if (pc_enable !== 1'b1 || id_pc !== 32'h0) begin failures++; $display("FAIL areset_outputs got pe=%b pc=%h exp 1 0", pc_enable, id_pc); end
        sb.delete();
        pc = 32'h4000;
        @(negedge clk);
        reset = 1'b1;
        #1;
        tick();
        checks++; if (id_pc !== 32'h4000 || count !== 3'd1) begin failures++; $display("FAIL areset_first_push got pc=%h count=%0d exp 00004000 1", id_pc, count); end
    endtask

    task automatic test_pc8_wrap();
        flush = 1'b1; target = 32'hFFFF_FFFC;
        tick();
        flush = 1'b0; id_ready = 1'b0;
        tick();
        checks++; if (id_pc !== 32'hFFFF_FFFC || id_pc8 !== 32'h0000_0004) begin failures++; $display("FAIL pc8_wrap got pc=%h pc8=%h exp fffffffc 00000004", id_pc, id_pc8); end
    endtask

    task automatic test_wrap_random();
        logic exp_pe;
        for (int i = 0; i < 40; i++) begin
            id_ready = 1'($urandom_range(0, 1));
            #1;
            exp_pe = (sb.size() < DEPTH) || (id_ready && sb.size() != 0);
            checks++; if (32'(count) !== sb.size() || id_valid !== (sb.size() != 0)) begin failures++; $display("FAIL rand_count[%0d] got=%0d valid=%b exp=%0d", i, count, id_valid, sb.size()); end
            checks++; if (pc_enable !== exp_pe) begin failures++; $display("FAIL rand_pc_enable[%0d] got=%b exp=%b", i, pc_enable, exp_pe); end
            if (sb.size() != 0) begin
                checks++; if ({id_pc, id_instr} !== sb[0] || id_pc8 !== sb[0][63:32] + 32'd8) begin failures++; $display("FAIL rand_head[%0d] got=%h %h %h exp=%h", i, id_pc, id_instr, id_pc8, sb[0]); end
            end
            tick();
        end
    endtask

    initial begin
        reset    = 1'b0;
        flush    = 1'b0;
        id_ready = 1'b0;
        pc       = 32'h3000;
        target   = 32'h0;
        test_reset();
        test_pass_through();
        test_fill();
        test_full_pop();
        test_flush_ready();
        test_async_reset();
        test_pc8_wrap();
        test_wrap_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
